// File: rtl/ysyx_22041207_mem_arbiter.sv
// Arbitrates the single data-memory port between instruction fetch and the LSU.
// One transaction in flight at a time; LSU has priority, bounded by a starvation streak.
module ysyx_22041207_mem_arbiter #(
  parameter int AW           = 64,
  parameter int DW           = 64,
  parameter int STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            if_req_valid,
  input  logic [AW-1:0]   if_req_addr,
  output logic            if_req_ready,
  input  logic            if_flush,
  output logic            if_resp_valid,
  output logic [DW-1:0]   if_resp_data,
  input  logic            ls_req_valid,
  input  logic            ls_req_wen,
  input  logic [AW-1:0]   ls_req_addr,
  input  logic [DW-1:0]   ls_req_wdata,
  input  logic [DW/8-1:0] ls_req_wmask,
  output logic            ls_req_ready,
  output logic            ls_resp_valid,
  output logic [DW-1:0]   ls_resp_data,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic            mem_req_wen,
  output logic [AW-1:0]   mem_req_addr,
  output logic [DW-1:0]   mem_req_wdata,
  output logic [DW/8-1:0] mem_req_wmask,
  input  logic            mem_resp_valid,
  input  logic [DW-1:0]   mem_resp_data,
  output logic            owner
);

  localparam int MW = DW / 8;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t          state_q, state_d;
  logic            owner_q, owner_d;
  logic            drop_q, drop_d;
  logic [SW-1:0]   streak_q, streak_d;
  logic            mem_req_valid_q, mem_req_valid_d;
  logic            wen_q, wen_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [MW-1:0]   wmask_q, wmask_d;

  logic in_idle, if_cand, ls_cand, grant_if, grant_ls, resp_fire;

  // Readys are gated by rst_n so nothing is granted while reset is held.
  assign in_idle   = (state_q == IDLE) && rst_n;
  assign if_cand   = if_req_valid && !if_flush;
  assign ls_cand   = ls_req_valid;
  assign grant_if  = in_idle && if_cand && (!ls_cand || (streak_q == LIMIT));
  assign grant_ls  = in_idle && ls_cand && !grant_if;
  assign resp_fire = (state_q == WAIT) && mem_resp_valid;

  always_comb begin
    state_d         = state_q;
    owner_d         = owner_q;
    drop_d          = drop_q;
    streak_d        = streak_q;
    mem_req_valid_d = mem_req_valid_q;
    wen_d           = wen_q;
    addr_d          = addr_q;
    wdata_d         = wdata_q;
    wmask_d         = wmask_q;
    case (state_q)
      IDLE: begin
        if (grant_if || grant_ls) begin
          state_d         = ISSUE;
          mem_req_valid_d = 1'b1;
          owner_d         = grant_ls;
          addr_d          = grant_ls ? ls_req_addr : if_req_addr;
          wen_d           = grant_ls && ls_req_wen;
          wdata_d         = grant_ls ? ls_req_wdata : '0;
          wmask_d         = (grant_ls && ls_req_wen) ? ls_req_wmask : '0;
          if (grant_if) begin
            streak_d = '0;
          end else if (if_req_valid && (streak_q != LIMIT)) begin
            streak_d = streak_q + SW'(1);
          end
        end
      end
      ISSUE: begin
        if (if_flush && !owner_q) drop_d = 1'b1;
        if (mem_req_ready) begin
          state_d         = WAIT;
          mem_req_valid_d = 1'b0;
        end
      end
      WAIT: begin
        if (if_flush && !owner_q) drop_d = 1'b1;
        if (mem_resp_valid) begin
          state_d = IDLE;
          drop_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      owner_q         <= 1'b0;
      drop_q          <= 1'b0;
      streak_q        <= '0;
      mem_req_valid_q <= 1'b0;
      wen_q           <= 1'b0;
      addr_q          <= '0;
      wdata_q         <= '0;
      wmask_q         <= '0;
    end else begin
      state_q         <= state_d;
      owner_q         <= owner_d;
      drop_q          <= drop_d;
      streak_q        <= streak_d;
      mem_req_valid_q <= mem_req_valid_d;
      wen_q           <= wen_d;
      addr_q          <= addr_d;
      wdata_q         <= wdata_d;
      wmask_q         <= wmask_d;
    end
  end

  // A flushed fetch still completes at memory but its response is swallowed.
  assign if_resp_valid = resp_fire && !owner_q && !drop_q && !if_flush;
  assign ls_resp_valid = resp_fire && owner_q;
  assign if_resp_data  = if_resp_valid ? mem_resp_data : '0;
  assign ls_resp_data  = ls_resp_valid ? mem_resp_data : '0;

  assign if_req_ready  = grant_if;
  assign ls_req_ready  = grant_ls;
  assign mem_req_valid = mem_req_valid_q;
  assign mem_req_wen   = wen_q;
  assign mem_req_addr  = addr_q;
  assign mem_req_wdata = wdata_q;
  assign mem_req_wmask = wmask_q;
  assign owner         = owner_q;

endmodule

// File: tb/tb_ysyx_22041207_mem_arbiter.sv
// Directed bench for the memory arbiter: fetch, store, starvation, flush, reset and
// spurious-response scenarios, each checked against hand-computed values.
module tb_ysyx_22041207_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req_valid;
  logic [63:0] if_req_addr;
  logic        if_req_ready;
  logic        if_flush;
  logic        if_resp_valid;
  logic [63:0] if_resp_data;
  logic        ls_req_valid;
  logic        ls_req_wen;
  logic [63:0] ls_req_addr;
  logic [63:0] ls_req_wdata;
  logic [7:0]  ls_req_wmask;
  logic        ls_req_ready;
  logic        ls_resp_valid;
  logic [63:0] ls_resp_data;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_req_wen;
  logic [63:0] mem_req_addr;
  logic [63:0] mem_req_wdata;
  logic [7:0]  mem_req_wmask;
  logic        mem_resp_valid;
  logic [63:0] mem_resp_data;
  logic        owner;

  int n_compared   = 0;
  int n_mismatched = 0;

  ysyx_22041207_mem_arbiter #(.AW(64), .DW(64), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(if_req_ready),
    .if_flush(if_flush), .if_resp_valid(if_resp_valid), .if_resp_data(if_resp_data),
    .ls_req_valid(ls_req_valid), .ls_req_wen(ls_req_wen), .ls_req_addr(ls_req_addr),
    .ls_req_wdata(ls_req_wdata), .ls_req_wmask(ls_req_wmask), .ls_req_ready(ls_req_ready),
    .ls_resp_valid(ls_resp_valid), .ls_resp_data(ls_resp_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_wen(mem_req_wen),
    .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data), .owner(owner)
  );

  always #5 clk = ~clk;

  // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; if_req_valid = 1'b0; if_req_addr = '0; if_flush = 1'b0;
    ls_req_valid = 1'b0; ls_req_wen = 1'b0; ls_req_addr = '0; ls_req_wdata = '0; ls_req_wmask = '0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;
    #3;
    n_compared++; if (mem_req_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_mem_req_valid: got %b want 0", mem_req_valid); end
    n_compared++; if ({if_req_ready, ls_req_ready, if_resp_valid, ls_resp_valid} !== 4'b0) begin n_mismatched++; $display("[TB] FAIL reset_handshakes: got %b want 0000", {if_req_ready, ls_req_ready, if_resp_valid, ls_resp_valid}); end
    n_compared++; if ({mem_req_addr, mem_req_wdata, mem_req_wmask, mem_req_wen, owner} !== '0) begin n_mismatched++; $display("[TB] FAIL reset_mem_fields: got addr %h wdata %h wmask %h wen %b owner %b want 0", mem_req_addr, mem_req_wdata, mem_req_wmask, mem_req_wen, owner); end
    n_compared++; if ({if_resp_data, ls_resp_data} !== '0) begin n_mismatched++; $display("[TB] FAIL reset_resp_data: got %h %h want 0", if_resp_data, ls_resp_data); end
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_single_fetch();
    tick();
    if_req_valid = 1'b1; if_req_addr = 64'h8000_0000;
    #1;
    n_compared++; if (if_req_ready !== 1'b1) begin n_mismatched++; $display("[TB] FAIL fetch_if_ready: got %b want 1", if_req_ready); end
    n_compared++; if (ls_req_ready !== 1'b0) begin n_mismatched++; $display("[TB] FAIL fetch_ls_ready: got %b want 0", ls_req_ready); end
    tick();
    if_req_valid = 1'b0; mem_req_ready = 1'b1;
    #1;
    n_compared++; if (mem_req_valid !== 1'b1) begin n_mismatched++; $display("[TB] FAIL fetch_mem_valid: got %b want 1", mem_req_valid); end
    n_compared++; if (mem_req_addr !== 64'h8000_0000) begin n_mismatched++; $display("[TB] FAIL fetch_mem_addr: got %h want 80000000", mem_req_addr); end
    n_compared++; if ({mem_req_wen, mem_req_wmask, owner} !== 10'b0) begin n_mismatched++; $display("[TB] FAIL fetch_wen_wmask_owner: got %b %h %b want 0", mem_req_wen, mem_req_wmask, owner); end
    tick();
    mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_resp_data = 64'h13;
    #1;
    n_compared++; if (if_resp_valid !== 1'b1) begin n_mismatched++; $display("[TB] FAIL fetch_resp_valid: got %b want 1", if_resp_valid); end
    n_compared++; if (if_resp_data !== 64'h13) begin n_mismatched++; $display("[TB] FAIL fetch_resp_data: got %h want 13", if_resp_data); end
    n_compared++; if ({ls_resp_valid, mem_req_valid} !== 2'b00) begin n_mismatched++; $display("[TB] FAIL fetch_ls_resp_mem_valid: got %b want 00", {ls_resp_valid, mem_req_valid}); end
    tick();
    mem_resp_valid = 1'b0; mem_resp_data = '0;
    #1;
    n_compared++; if ({if_resp_valid, if_resp_data} !== 65'b0) begin n_mismatched++; $display("[TB] FAIL fetch_resp_after: got %b %h want 0", if_resp_valid, if_resp_data); end
  endtask

  task automatic test_store();
    tick();
    ls_req_valid = 1'b1; ls_req_wen = 1'b1; ls_req_addr = 64'h8000_1000;
    ls_req_wdata = 64'hDEAD_BEEF; ls_req_wmask = 8'h0F;
    #1;
    n_compared++; if ({ls_req_ready, if_req_ready} !== 2'b10) begin n_mismatched++; $display("[TB] FAIL store_readys: got %b want 10", {ls_req_ready, if_req_ready}); end
    tick();
    ls_req_valid = 1'b0; ls_req_wen = 1'b0; ls_req_addr = '0; ls_req_wdata = '0; ls_req_wmask = '0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_compared++; if ({mem_req_valid, mem_req_wen} !== 2'b11) begin n_mismatched++; $display("[TB] FAIL store_hold_valid_wen[%0d]: got %b want 11", i, {mem_req_valid, mem_req_wen}); end
      n_compared++; if (mem_req_addr !== 64'h8000_1000) begin n_mismatched++; $display("[TB] FAIL store_hold_addr[%0d]: got %h want 80001000", i, mem_req_addr); end
      n_compared++; if (mem_req_wdata !== 64'hDEAD_BEEF) begin n_mismatched++; $display("[TB] FAIL store_hold_wdata[%0d]: got %h want deadbeef", i, mem_req_wdata); end
      n_compared++; if (mem_req_wmask !== 8'h0F) begin n_mismatched++; $display("[TB] FAIL store_hold_wmask[%0d]: got %h want 0f", i, mem_req_wmask); end
      tick();
    end
    mem_req_ready = 1'b1;
    #1;
    n_compared++; if (mem_req_valid !== 1'b1) begin n_mismatched++; $display("[TB] FAIL store_valid_at_ready: got %b want 1", mem_req_valid); end
    tick();
    mem_req_ready = 1'b0;
    #1;
    n_compared++; if ({mem_req_valid, ls_resp_valid} !== 2'b00) begin n_mismatched++; $display("[TB] FAIL store_wait_no_resp: got %b want 00", {mem_req_valid, ls_resp_valid}); end
    tick();
    mem_resp_valid = 1'b1;
    #1;
    n_compared++; if ({ls_resp_valid, if_resp_valid, owner} !== 3'b101) begin n_mismatched++; $display("[TB] FAIL store_ack: got %b want 101", {ls_resp_valid, if_resp_valid, owner}); end
    tick();
    mem_resp_valid = 1'b0;
    #1;
    n_compared++; if (ls_resp_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL store_ack_once: got %b want 0", ls_resp_valid); end
  endtask

  // Both requesters always valid: four LSU grants then one IF grant, repeated.
  task automatic test_starvation();
    logic exp_if;
    tick();
    if_req_valid = 1'b1; if_req_addr = 64'h8000_0040;
    ls_req_valid = 1'b1; ls_req_wen = 1'b0; ls_req_addr = 64'h8000_2000;
    mem_req_ready = 1'b1;
    for (int g = 0; g < 10; g++) begin
      exp_if = (g == 4) || (g == 9);
      #1;
      n_compared++; if ({if_req_ready, ls_req_ready} !== {exp_if, !exp_if}) begin n_mismatched++; $display("[TB] FAIL starve_grant[%0d]: got if/ls %b%b want %b%b", g, if_req_ready, ls_req_ready, exp_if, !exp_if); end
      tick();
      #1;
      n_compared++; if (owner !== !exp_if) begin n_mismatched++; $display("[TB] FAIL starve_owner[%0d]: got %b want %b", g, owner, !exp_if); end
      tick();
      mem_resp_valid = 1'b1; mem_resp_data = 64'(g + 100);
      #1;
      n_compared++; if ({if_resp_valid, ls_resp_valid} !== {exp_if, !exp_if}) begin n_mismatched++; $display("[TB] FAIL starve_resp[%0d]: got if/ls %b%b want %b%b", g, if_resp_valid, ls_resp_valid, exp_if, !exp_if); end
      tick();
      mem_resp_valid = 1'b0; mem_resp_data = '0;
    end
    if_req_valid = 1'b0; ls_req_valid = 1'b0; mem_req_ready = 1'b0;
  endtask

  task automatic test_flush();
    tick();
    if_req_valid = 1'b1; if_req_addr = 64'h8000_0100; if_flush = 1'b1;
    #1;
    n_compared++; if (if_req_ready !== 1'b0) begin n_mismatched++; $display("[TB] FAIL flush_idle_block: got %b want 0", if_req_ready); end
    tick();
    if_flush = 1'b0;
    #1;
    n_compared++; if (if_req_ready !== 1'b1) begin n_mismatched++; $display("[TB] FAIL flush_grant_after: got %b want 1", if_req_ready); end
    tick();
    if_req_valid = 1'b0; mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0; if_flush = 1'b1;
    tick();
    if_flush = 1'b0; mem_resp_valid = 1'b1; mem_resp_data = 64'h1234;
    #1;
    n_compared++; if ({if_resp_valid, if_resp_data} !== 65'b0) begin n_mismatched++; $display("[TB] FAIL flush_drop_resp: got %b %h want 0", if_resp_valid, if_resp_data); end
    tick();
    mem_resp_valid = 1'b0; mem_resp_data = '0; if_req_valid = 1'b1; if_req_addr = 64'h8000_0104;
    #1;
    n_compared++; if (if_req_ready !== 1'b1) begin n_mismatched++; $display("[TB] FAIL flush_next_grant: got %b want 1", if_req_ready); end
    tick();
    if_req_valid = 1'b0; mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_resp_data = 64'hABCD; if_flush = 1'b1;
    #1;
    n_compared++; if (if_resp_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL flush_same_cycle: got %b want 0", if_resp_valid); end
    tick();
    mem_resp_valid = 1'b0; if_flush = 1'b0; if_req_valid = 1'b1; if_req_addr = 64'h8000_0108;
    tick();
    if_req_valid = 1'b0; mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_resp_data = 64'h5678;
    #1;
    n_compared++; if ({if_resp_valid, if_resp_data} !== {1'b1, 64'h5678}) begin n_mismatched++; $display("[TB] FAIL flush_recovered: got %b %h want 1 5678", if_resp_valid, if_resp_data); end
    tick();
    mem_resp_valid = 1'b0; mem_resp_data = '0;
  endtask

  task automatic test_reset_mid_issue();
    tick();
    ls_req_valid = 1'b1; ls_req_wen = 1'b0; ls_req_addr = 64'h8000_2000;
    tick();
    ls_req_valid = 1'b0;
    #1;
    n_compared++; if ({mem_req_valid, owner} !== 2'b11) begin n_mismatched++; $display("[TB] FAIL rst_mid_pre: got %b want 11", {mem_req_valid, owner}); end
    #2;
    rst_n = 1'b0;
    #1;
    n_compared++; if ({mem_req_valid, owner, mem_req_addr} !== 66'b0) begin n_mismatched++; $display("[TB] FAIL rst_mid_async: got %b %b %h want 0", mem_req_valid, owner, mem_req_addr); end
    tick();
    mem_resp_valid = 1'b1; mem_resp_data = 64'h55;
    #1;
    n_compared++; if ({ls_resp_valid, if_resp_valid} !== 2'b00) begin n_mismatched++; $display("[TB] FAIL rst_mid_resp_in_reset: got %b want 00", {ls_resp_valid, if_resp_valid}); end
    tick();
    rst_n = 1'b1;
    #1;
    n_compared++; if ({ls_resp_valid, if_resp_valid, mem_req_valid} !== 3'b000) begin n_mismatched++; $display("[TB] FAIL rst_mid_resp_after: got %b want 000", {ls_resp_valid, if_resp_valid, mem_req_valid}); end
    tick();
    mem_resp_valid = 1'b0; mem_resp_data = '0; if_req_valid = 1'b1; if_req_addr = 64'h8000_0200;
    #1;
    n_compared++; if (if_req_ready !== 1'b1) begin n_mismatched++; $display("[TB] FAIL rst_mid_idle_grant: got %b want 1", if_req_ready); end
    tick();
    if_req_valid = 1'b0; mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_resp_data = 64'h77;
    #1;
    n_compared++; if ({if_resp_valid, if_resp_data} !== {1'b1, 64'h77}) begin n_mismatched++; $display("[TB] FAIL rst_mid_followup: got %b %h want 1 77", if_resp_valid, if_resp_data); end
    tick();
    mem_resp_valid = 1'b0; mem_resp_data = '0;
  endtask

  task automatic test_spurious_resp();
    tick();
    mem_resp_valid = 1'b1; mem_resp_data = 64'h99;
    #1;
    n_compared++; if ({if_resp_valid, ls_resp_valid, mem_req_valid, ls_resp_data} !== 67'b0) begin n_mismatched++; $display("[TB] FAIL spur_idle: got %b %b %b %h want 0", if_resp_valid, ls_resp_valid, mem_req_valid, ls_resp_data); end
    tick();
    mem_resp_valid = 1'b0; ls_req_valid = 1'b1; ls_req_wen = 1'b0; ls_req_addr = 64'h8000_3000;
    #1;
    n_compared++; if (ls_req_ready !== 1'b1) begin n_mismatched++; $display("[TB] FAIL spur_still_idle: got %b want 1", ls_req_ready); end
    tick();
    ls_req_valid = 1'b0; mem_resp_valid = 1'b1;
    #1;
    n_compared++; if (ls_resp_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL spur_issue: got %b want 0", ls_resp_valid); end
    tick();
    mem_resp_valid = 1'b0;
    #1;
    n_compared++; if (mem_req_valid !== 1'b1) begin n_mismatched++; $display("[TB] FAIL spur_issue_held: got %b want 1", mem_req_valid); end
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_resp_data = 64'hCAFE; if_flush = 1'b1;
    #1;
    n_compared++; if ({ls_resp_valid, ls_resp_data} !== {1'b1, 64'hCAFE}) begin n_mismatched++; $display("[TB] FAIL spur_ls_flush_immune: got %b %h want 1 cafe", ls_resp_valid, ls_resp_data); end
    tick();
    mem_resp_valid = 1'b0; mem_resp_data = '0; if_flush = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_store();
    test_starvation();
    test_flush();
    test_reset_mid_issue();
    test_spurious_resp();
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/ysyx_22041207_mem_arbiter.md
Name: ysyx_22041207_mem_arbiter

Overview:
- Shares the single data-memory port between the IF stage (instruction fetch, read-only) and the ME stage load/store unit (LSU).
- Handles one transaction at a time using valid/ready requests and a single-cycle response pulse.
- The LSU normally has priority. A starvation counter guarantees that IF eventually wins.
- Handles pipeline flush by squashing the response to an IF request that is already in flight.

Parameters:
AW, 64, address width
DW, 64, data width (write mask width is DW/8)
STARVE_LIMIT, 4, number of consecutive LSU grants made while IF is waiting before IF is forced to win; must be >= 1

Ports:
clk  in  1  clock; all state updates on the rising edge
rst_n  in  1  asynchronous active-low reset
if_req_valid  in  1  fetch request
if_req_addr  in  AW  fetch address
if_req_ready  out  1  fetch request accepted this cycle
if_flush  in  1  pipeline flush; cancels the pending or in-flight fetch
if_resp_valid  out  1  fetch data valid (1-cycle pulse)
if_resp_data  out  DW  fetch data
ls_req_valid  in  1  LSU request
ls_req_wen  in  1  1 = store, 0 = load
ls_req_addr  in  AW  LSU address
ls_req_wdata  in  DW  store data
ls_req_wmask  in  DW/8  store byte mask
ls_req_ready  out  1  LSU request accepted this cycle
ls_resp_valid  out  1  load data or store ack (1-cycle pulse)
ls_resp_data  out  DW  load data
mem_req_valid  out  1  request to memory
mem_req_ready  in  1  memory accepts the request
mem_req_wen  out  1  write enable
mem_req_addr  out  AW  address
mem_req_wdata  out  DW  write data
mem_req_wmask  out  DW/8  byte mask (0 for reads)
mem_resp_valid  in  1  memory response (read data or write ack)
mem_resp_data  in  DW  read data
owner  out  1  0 = IF, 1 = LSU; owner of the current transaction (debug)

Behaviour:
- Reset (rst_n=0, async):
  - FSM goes to IDLE; all out ports are 0.
  - Starvation counter cleared; drop flag cleared; latched request registers cleared.
  - Any mem_resp_valid arriving after reset is ignored, since IDLE ignores responses.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE, grant selection (combinational):
  - Candidate set: IF if (if_req_valid & ~if_flush); LSU if ls_req_valid.
  - Both candidates present: LSU wins unless streak == STARVE_LIMIT, in which case IF wins.
  - Winner's *_req_ready = 1; loser's ready = 0; with no candidate, both readys are 0.
  - On grant: latch addr / wen / wdata / wmask and owner. IF requests latch wen=0, wmask=0. Go to ISSUE.
- Streak counter (updated on a grant only):
  - LSU granted while if_req_valid=1: streak+1, saturating at STARVE_LIMIT.
  - IF granted: streak=0.
  - LSU granted while IF is idle: streak unchanged.
- ISSUE:
  - mem_req_valid=1 with the latched fields held stable.
  - On mem_req_ready=1, go to WAIT.
  - The request is never retracted, even on flush.
- WAIT:
  - mem_req_valid=0.
  - On mem_resp_valid=1, pulse the owner's *_resp_valid combinationally in the same cycle, with data passed through from mem_resp_data. Go to IDLE.
  - Store responses carry ack only; ls_resp_data = mem_resp_data and is don't-care.
- Latency:
  - Grant at cycle N → mem_req_valid from N+1.
  - With mem_req_ready=1 at N+1 and mem_resp_valid at N+2: resp pulse at N+2, IDLE at N+3.
  - Minimum 3 cycles from grant to the next grant.
- Flush:
  - if_flush=1 in IDLE blocks IF from being granted that cycle.
  - if_flush=1 while owner=IF in ISSUE or WAIT sets the drop flag.
  - Drop flag set: the IF response is suppressed (if_resp_valid stays 0) and the transaction still completes at memory.
  - Drop flag clears on return to IDLE.
  - if_flush in the same cycle as mem_resp_valid also suppresses the response.
  - Flush never affects LSU transactions.
- Spurious mem_resp_valid in IDLE or ISSUE: ignored, no state change.
- Requester valids are not required to stay high; a deasserted request is simply not granted.
- *_resp_data is 0 whenever the corresponding *_resp_valid=0.

Test Plan:
- Single fetch, mem_req_ready=1, response 0x00000013 one cycle after the handshake → if_req_ready at N; mem_req_valid at N+1 with addr 0x80000000, wen=0; if_resp_valid pulse at N+2 with data 0x00000013.
- Store: LSU wen=1, addr 0x80001000, wdata 0xDEADBEEF, wmask 0x0F, memory ready delayed 3 cycles → mem_req fields held stable for all 3 cycles; ls_resp_valid pulses once after the ack.
- Both requesters valid continuously, STARVE_LIMIT=4 → grant order LSU, LSU, LSU, LSU, IF, LSU, …; streak reads 0 after the IF grant.
- IF in WAIT, if_flush pulsed, then mem_resp_valid with 0x1234 → if_resp_valid stays 0; FSM returns to IDLE; the next IF request is granted normally.
- rst_n dropped mid-ISSUE → all outputs 0 immediately (asynchronous); a later mem_resp_valid produces no resp pulse; FSM is in IDLE after release.
- mem_resp_valid asserted while in IDLE → no resp pulse, no state change.
